// File: rtl/cp0_ctrl.sv
// cp0_ctrl: CP0 coprocessor controller for the five-stage MIPS core.
// Owns Status, Cause, EPC, BadVAddr, Count and Compare; arbitrates
// exceptions/interrupts at write-back and drives flush/vector/ERET targets.
// Ports:
//   clk, reset           - single clock, async active-high reset
//   exception[8:0]       - {sys, mfc0, mtc0, eret, break, ov, adel, ades, ri}
//   c0_addr, c0_wdata    - CP0 register number and MTC0 write data
//   wb_valid, wb_bd      - write-back instruction valid / in delay slot
//   wb_pc, wb_badvaddr   - write-back PC and faulting address
//   ext_int_in           - asynchronous external interrupt levels
//   c0_valid, c0_res     - MFC0 valid and read data
//   eret_flush, eret_pc  - ERET redirect and target (EPC)
//   ex_flush, ex_pc      - exception redirect and vector
//   timer_irq            - Cause.TI
module cp0_ctrl #(
  parameter int EXT_INT_W   = 6,
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8:0]           exception,
  input  logic [4:0]           c0_addr,
  input  logic [31:0]          c0_wdata,
  input  logic                 wb_valid,
  input  logic                 wb_bd,
  input  logic [31:0]          wb_pc,
  input  logic [31:0]          wb_badvaddr,
  input  logic [EXT_INT_W-1:0] ext_int_in,
  output logic                 c0_valid,
  output logic [31:0]          c0_res,
  output logic                 eret_flush,
  output logic [31:0]          eret_pc,
  output logic                 ex_flush,
  output logic [31:0]          ex_pc,
  output logic                 timer_irq
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [4:0] A_BADV   = 5'd8;
  localparam logic [4:0] A_COUNT  = 5'd9;
  localparam logic [4:0] A_CMP    = 5'd11;
  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;

  logic w_op_sys, w_op_mfc0, w_op_mtc0, w_op_eret;
  logic w_op_brk, w_op_ov, w_op_adel, w_op_ades, w_op_ri;
  assign {w_op_sys, w_op_mfc0, w_op_mtc0, w_op_eret,
          w_op_brk, w_op_ov, w_op_adel, w_op_ades, w_op_ri} = exception;

  logic [7:0]           r_im;
  logic                 r_exl, r_ie, r_bd, r_ti;
  logic [4:0]           r_exc;
  logic [1:0]           r_ip_sw;
  logic [31:0]          r_epc, r_badv, r_count, r_compare;
  logic [PW-1:0]        r_presc;
  logic [EXT_INT_W-1:0] r_sync [SYNC_STAGES];

  // BEV is read-only and comes out of reset as 1, so it is a constant.
  logic w_bev;
  assign w_bev = 1'b1;

  // Hardware IP[7:2]; lines beyond EXT_INT_W read 0, IP7 also carries TI.
  logic [EXT_INT_W-1:0] w_sync_q;
  logic [5:0]           w_ext_ip;
  logic [7:0]           w_ip;
  assign w_sync_q = r_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < 6; g++) begin : g_ip
    if (g < EXT_INT_W) begin : g_on
      assign w_ext_ip[g] = w_sync_q[g];
    end else begin : g_off
      assign w_ext_ip[g] = 1'b0;
    end
  end

  assign w_ip = {w_ext_ip[5] | r_ti, w_ext_ip[4:0], r_ip_sw};

  logic       w_int_pending;
  logic [4:0] w_code;
  logic       w_mtc0_we, w_cmp_wr, w_cnt_wr, w_bad_wr;

  assign w_int_pending = (|(w_ip & r_im)) & r_ie & ~r_exl;
  assign ex_flush = wb_valid & (w_int_pending | w_op_sys | w_op_brk | w_op_ov |
                                w_op_adel | w_op_ades | w_op_ri);

  always_comb begin
    w_code = EXC_ADES;
    if (w_int_pending)  w_code = EXC_INT;
    else if (w_op_adel) w_code = EXC_ADEL;
    else if (w_op_ri)   w_code = EXC_RI;
    else if (w_op_ov)   w_code = EXC_OV;
    else if (w_op_brk)  w_code = EXC_BP;
    else if (w_op_sys)  w_code = EXC_SYS;
  end

  assign w_bad_wr  = (w_code == EXC_ADEL) || (w_code == EXC_ADES);
  assign w_mtc0_we = wb_valid & w_op_mtc0 & ~ex_flush;
  assign w_cmp_wr  = w_mtc0_we && (c0_addr == A_CMP);
  assign w_cnt_wr  = w_mtc0_we && (c0_addr == A_COUNT);

  assign eret_flush = w_op_eret & wb_valid & ~ex_flush;
  assign c0_valid   = w_op_mfc0 & wb_valid;
  assign eret_pc    = r_epc;
  assign ex_pc      = w_bev ? 32'hBFC0_0380 : 32'h8000_0180;
  assign timer_irq  = r_ti;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= ext_int_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // A Count load restarts the prescale period and beats a coincident wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_presc <= '0;
    end else if (w_cnt_wr) begin
      r_count <= c0_wdata;
      r_presc <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_count <= r_count + 32'd1;
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_ti <= 1'b0;
    else if (w_cmp_wr)               r_ti <= 1'b0;
    else if (r_count == r_compare)   r_ti <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_exc     <= '0;
      r_ip_sw   <= '0;
      r_epc     <= '0;
      r_badv    <= '0;
      r_compare <= 32'hFFFF_FFFF;
    end else begin
      if (ex_flush) begin
        r_exc <= w_code;
        r_exl <= 1'b1;
        // Nested exceptions keep the original return point.
        if (!r_exl) begin
          r_epc <= wb_bd ? wb_pc - 32'd4 : wb_pc;
          r_bd  <= wb_bd;
        end
        if (w_bad_wr) r_badv <= wb_badvaddr;
      end else if (eret_flush) begin
        r_exl <= 1'b0;
      end
      if (w_mtc0_we) begin
        case (c0_addr)
          A_STATUS: begin
            r_im  <= c0_wdata[15:8];
            r_exl <= c0_wdata[1];
            r_ie  <= c0_wdata[0];
          end
          A_CAUSE: r_ip_sw   <= c0_wdata[9:8];
          A_EPC:   r_epc     <= c0_wdata;
          A_CMP:   r_compare <= c0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    c0_res = '0;
    case (c0_addr)
      A_BADV:   c0_res = r_badv;
      A_COUNT:  c0_res = r_count;
      A_CMP:    c0_res = r_compare;
      A_STATUS: c0_res = {9'd0, w_bev, 6'd0, r_im, 6'd0, r_exl, r_ie};
      A_CAUSE:  c0_res = {r_bd, r_ti, 14'd0, w_ip, 1'b0, r_exc, 2'b00};
      A_EPC:    c0_res = r_epc;
      default:  c0_res = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed scenarios plus randomized traffic for cp0_ctrl,
// checked every cycle against a behavioural model of the CP0 rules.
module tb_cp0_ctrl;
  localparam int EW = 1;
  localparam int CD = 3;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [8:0]    exception;
  logic [4:0]    c0_addr;
  logic [31:0]   c0_wdata, wb_pc, wb_badvaddr;
  logic          wb_valid, wb_bd;
  logic [EW-1:0] ext_int_in;
  logic          c0_valid, eret_flush, ex_flush, timer_irq;
  logic [31:0]   c0_res, eret_pc, ex_pc;

  cp0_ctrl #(.EXT_INT_W(EW), .COUNT_DIV(CD), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .exception(exception), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .wb_valid(wb_valid), .wb_bd(wb_bd), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .ext_int_in(ext_int_in), .c0_valid(c0_valid),
    .c0_res(c0_res), .eret_flush(eret_flush), .eret_pc(eret_pc),
    .ex_flush(ex_flush), .ex_pc(ex_pc), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: Count is base + elapsed clocks / divider.
  logic [7:0]    m_im;
  logic          m_exl, m_ie, m_bd, m_ti;
  logic [4:0]    m_code;
  logic [1:0]    m_ipsw;
  logic [31:0]   m_epc, m_bad, m_cmp, m_cbase;
  int unsigned   m_ticks;
  logic [EW-1:0] m_q[$];

  logic        e_flush, e_eret, e_valid, e_mtc0;
  logic [4:0]  e_code;
  logic [31:0] e_res;

  task automatic model_reset();
    m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_code = '0; m_ipsw = '0;
    m_epc = '0; m_bad = '0; m_cmp = 32'hFFFF_FFFF; m_cbase = '0; m_ticks = 0;
    m_q.delete();
    for (int i = 0; i < SS; i++) m_q.push_back('0);
  endtask

  function automatic logic [31:0] m_count();
    return m_cbase + 32'(m_ticks / CD);
  endfunction

  function automatic logic [7:0] m_ip();
    logic [7:0]    ip;
    logic [EW-1:0] s;
    s  = m_q[0];
    ip = {6'd0, m_ipsw};
    for (int j = 0; j < 6; j++) if (j < EW) ip[j+2] = s[j];
    ip[7] = ip[7] | m_ti;
    return ip;
  endfunction

  task automatic model_comb();
    logic sys, mfc0, mtc0, eret, brk, ov, adel, ades, ri, intp;
    logic [7:0] ip;
    {sys, mfc0, mtc0, eret, brk, ov, adel, ades, ri} = exception;
    ip   = m_ip();
    intp = (|(ip & m_im)) && m_ie && !m_exl;
    e_flush = wb_valid && (intp || sys || brk || ov || adel || ades || ri);
    if (intp)      e_code = 5'h00;
    else if (adel) e_code = 5'h04;
    else if (ri)   e_code = 5'h0a;
    else if (ov)   e_code = 5'h0c;
    else if (brk)  e_code = 5'h09;
    else if (sys)  e_code = 5'h08;
    else           e_code = 5'h05;
    e_eret  = eret && wb_valid && !e_flush;
    e_mtc0  = mtc0 && wb_valid && !e_flush;
    e_valid = mfc0 && wb_valid;
    case (c0_addr)
      5'd8:    e_res = m_bad;
      5'd9:    e_res = m_count();
      5'd11:   e_res = m_cmp;
      5'd12:   e_res = {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
      5'd13:   e_res = {m_bd, m_ti, 14'd0, ip, 1'b0, m_code, 2'b00};
      5'd14:   e_res = m_epc;
      default: e_res = 32'd0;
    endcase
  endtask

  task automatic model_update();
    logic [31:0] cnt;
    cnt = m_count();
    if (e_mtc0 && c0_addr == 5'd11) m_ti = 0;
    else if (cnt == m_cmp)          m_ti = 1;
    if (e_mtc0 && c0_addr == 5'd9) begin
      m_cbase = c0_wdata; m_ticks = 0;
    end else begin
      m_ticks++;
    end
    if (e_flush) begin
      if (!m_exl) begin
        m_epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
        m_bd  = wb_bd;
      end
      m_code = e_code;
      m_exl  = 1;
      if (e_code == 5'h04 || e_code == 5'h05) m_bad = wb_badvaddr;
    end else if (e_eret) begin
      m_exl = 0;
    end
    if (e_mtc0) begin
      case (c0_addr)
        5'd12: begin m_im = c0_wdata[15:8]; m_exl = c0_wdata[1]; m_ie = c0_wdata[0]; end
        5'd13: m_ipsw = c0_wdata[9:8];
        5'd14: m_epc = c0_wdata;
        5'd11: m_cmp = c0_wdata;
        default: ;
      endcase
    end
    m_q.push_back(ext_int_in);
    void'(m_q.pop_front());
  endtask

  // One clock: compare every output mid-cycle, then advance the model.
  task automatic step();
    @(negedge clk);
    model_comb();
    chk("ex_flush",   32'(ex_flush),   32'(e_flush));
    chk("eret_flush", 32'(eret_flush), 32'(e_eret));
    chk("c0_valid",   32'(c0_valid),   32'(e_valid));
    chk("c0_res",     c0_res,          e_res);
    chk("eret_pc",    eret_pc,         m_epc);
    chk("ex_pc",      ex_pc,           32'hBFC0_0380);
    chk("timer_irq",  32'(timer_irq),  32'(m_ti));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    exception = '0; c0_addr = '0; c0_wdata = '0; wb_valid = 0; wb_bd = 0;
    wb_pc = '0; wb_badvaddr = '0;
  endtask

  task automatic do_op(input logic [8:0] ex, input logic [4:0] addr, input logic [31:0] data);
    exception = ex; wb_valid = 1; c0_addr = addr; c0_wdata = data;
    step();
    set_idle();
  endtask

  task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
    exception = 9'b010000000; wb_valid = 1; c0_addr = addr;
    #1;
    chk(tag, c0_res, exp);
    step();
    set_idle();
  endtask

  localparam logic [8:0] OP_MTC0 = 9'b001000000;
  localparam logic [8:0] OP_ERET = 9'b000100000;

  initial begin
    set_idle();
    ext_int_in = '0;
    reset = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;

    rd(5'd12, "rst_status", 32'h0040_0000);
    rd(5'd13, "rst_cause", 32'h0000_0000);
    rd(5'd11, "rst_compare", 32'hFFFF_FFFF);
    chk("rst_ex_pc", ex_pc, 32'hBFC0_0380);

    // Count load and prescaled increment
    do_op(OP_MTC0, 5'd9, 32'd5);
    rd(5'd9, "cnt_load", 32'd5);
    step();
    step();
    rd(5'd9, "cnt_inc", 32'd6);

    // Compare match raises TI
    do_op(OP_MTC0, 5'd11, 32'd8);
    for (int i = 0; i < 40; i++) begin
      if (timer_irq) break;
      step();
    end
    chk("ti_rise", 32'(timer_irq), 32'd1);

    // Timer interrupt taken via IM7/IE
    do_op(OP_MTC0, 5'd12, 32'h0000_8001);
    wb_valid = 1; wb_pc = 32'h0000_0100;
    #1 chk("int_flush", 32'(ex_flush), 32'd1);
    step();
    set_idle();
    rd(5'd13, "int_cause", 32'h4000_8000);
    rd(5'd12, "int_status", 32'h0040_8003);
    rd(5'd14, "int_epc", 32'h0000_0100);
    exception = 9'b100000000; wb_valid = 1; wb_bd = 1; wb_pc = 32'h0000_0200;
    #1 chk("sys_flush", 32'(ex_flush), 32'd1);
    step();
    set_idle();
    rd(5'd14, "epc_keep", 32'h0000_0100);
    rd(5'd13, "sys_cause", 32'h4000_8020);
    do_op(OP_MTC0, 5'd11, 32'hFFFF_0000);
    chk("ti_clr", 32'(timer_irq), 32'd0);
    do_op(OP_ERET, 5'd0, 32'd0);

    // adel beats ri, delay-slot EPC and BadVAddr capture
    exception = 9'b000000101; wb_valid = 1; wb_bd = 1;
    wb_pc = 32'hBFC0_0100; wb_badvaddr = 32'h0000_0003;
    step();
    set_idle();
    rd(5'd13, "adel_cause", 32'h8000_0010);
    rd(5'd14, "adel_epc", 32'hBFC0_00FC);
    rd(5'd8, "adel_badv", 32'h0000_0003);
    do_op(OP_ERET, 5'd0, 32'd0);

    // ERET alone, then ERET with overflow
    do_op(OP_MTC0, 5'd14, 32'h0000_1234);
    exception = OP_ERET; wb_valid = 1;
    #1;
    chk("eret_flush", 32'(eret_flush), 32'd1);
    chk("eret_pc", eret_pc, 32'h0000_1234);
    step();
    set_idle();
    rd(5'd12, "eret_status", 32'h0040_8001);
    exception = OP_ERET | 9'b000001000; wb_valid = 1;
    #1;
    chk("eret_ov_eret", 32'(eret_flush), 32'd0);
    chk("eret_ov_flush", 32'(ex_flush), 32'd1);
    step();
    set_idle();
    rd(5'd13, "ov_cause", 32'h0000_0030);
    rd(5'd12, "ov_status", 32'h0040_8003);
    do_op(OP_ERET, 5'd0, 32'd0);

    // Synchroniser latency and asynchronous reset mid-pulse
    do_op(OP_MTC0, 5'd12, 32'h0000_0401);
    c0_addr = 5'd13;
    ext_int_in = '1;
    step();
    chk("ip2_1edge", 32'(c0_res[10]), 32'd0);
    step();
    chk("ip2_2edge", 32'(c0_res[10]), 32'd1);
    #1 reset = 1;
    #1;
    chk("ip2_rst", 32'(c0_res[10]), 32'd0);
    chk("cause_rst", c0_res, 32'd0);
    model_reset();
    #1 reset = 0;
    ext_int_in = '0;
    set_idle();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] addrs [7];
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
      exception = '0;
      for (int b = 0; b < 9; b++) if ($urandom_range(0, 11) == 0) exception[b] = 1'b1;
      if ($urandom_range(0, 3) == 0) exception[6] = 1'b1;
      if ($urandom_range(0, 3) == 0) exception[7] = 1'b1;
      if ($urandom_range(0, 7) == 0) exception[5] = 1'b1;
      wb_valid = ($urandom_range(0, 3) != 0);
      c0_addr  = addrs[$urandom_range(0, 6)];
      if (c0_addr == 5'd0) c0_addr = 5'($urandom_range(0, 31));
      c0_wdata = $urandom;
      if (c0_addr == 5'd11 && $urandom_range(0, 1) == 1)
        c0_wdata = m_count() + 32'($urandom_range(0, 6));
      wb_bd       = 1'($urandom_range(0, 1));
      wb_pc       = $urandom & 32'hFFFF_FFFC;
      wb_badvaddr = $urandom;
      if ($urandom_range(0, 3) == 0) ext_int_in = EW'($urandom);
      step();
    end
    set_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Parametrised CP0 coprocessor controller for the five-stage MIPS core. It sits beside the write-back stage and owns the Status, Cause, EPC, BadVAddr, Count and Compare registers. It arbitrates exceptions and interrupts, and drives flush, exception-vector and ERET-target signals to the fetch stage. Compared with the previous generation it adds a configurable external-interrupt width, a configurable Count prescaler, an input synchroniser on external interrupts, a computed exception vector, and full asynchronous reset of all state.

## Interface
Parameters:
- EXT_INT_W, 6: number of external hardware interrupt lines, 1..6; they map onto Cause.IP[2+EXT_INT_W-1:2] and unused IP bits read 0.
- COUNT_DIV, 2: Count increments once every COUNT_DIV clocks; must be ≥1.
- SYNC_STAGES, 2: flip-flop stages on ext_int_in; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- exception  in  9  {op_sys, op_mfc0, op_mtc0, op_eret, op_break, over_flow, adel, ades, ri}, MSB first.
- c0_addr  in  5  CP0 register number (Count 9, Compare 11, Status 12, Cause 13, EPC 14, BadVAddr 8).
- c0_wdata  in  32  MTC0 write data.
- wb_valid  in  1  the write-back instruction is valid.
- wb_bd  in  1  the write-back instruction is in a delay slot.
- wb_pc  in  32  PC of the write-back instruction.
- wb_badvaddr  in  32  faulting address for adel/ades.
- ext_int_in  in  EXT_INT_W  asynchronous external interrupt levels.
- c0_valid  out  1  op_mfc0 & wb_valid.
- c0_res  out  32  MFC0 read data; 0 for unimplemented addresses.
- eret_flush  out  1  op_eret & wb_valid & ~ex_flush.
- eret_pc  out  32  current EPC.
- ex_flush  out  1  an exception or interrupt is taken this cycle.
- ex_pc  out  32  exception vector: 32'hBFC0_0380 if Status.BEV, else 32'h8000_0180.
- timer_irq  out  1  current Cause.TI.

## Operation
- Reset values: Status.BEV=1; IM, EXL, IE=0; Cause all 0; EPC, BadVAddr, Count, prescaler=0; Compare=32'hFFFF_FFFF; sync flops 0.
- Interrupt request: int_pending = |(Cause.IP & Status.IM) & IE & ~EXL.
- Exception taken: ex_flush = wb_valid & (int_pending | sys | break | ov | adel | ades | ri).
- ExcCode priority, highest first: INT 0x00, ADEL 0x04, RI 0x0a, OV 0x0c, BP 0x09, SYS 0x08, ADES 0x05.
- On ex_flush:
  - ExcCode and EXL←1 always.
  - If EXL was 0: EPC←wb_bd ? wb_pc−4 : wb_pc, and BD←wb_bd.
  - BadVAddr←wb_badvaddr when the chosen code is ADEL or ADES, regardless of EXL.
- On eret_flush: EXL←0.
- MTC0 commits only when wb_valid & op_mtc0 & ~ex_flush.
  - Status writes IM[15:8], EXL[1] and IE[0]; BEV is read-only.
  - Cause writes IP[1:0] from bits [9:8].
  - EPC, Count and Compare take the full word.
  - A Compare write clears TI.
- Count prescaler:
  - The prescaler counts 0..COUNT_DIV−1; Count increments when the prescaler wraps.
  - An MTC0 to Count loads the value and zeroes the prescaler.
  - Count wraps 0xFFFF_FFFF→0.
- TI is set on any cycle where Count==Compare and no Compare write occurs; it stays set until a Compare write or reset.
- Cause.IP[7] = sync(ext_int_in[5]) | TI when EXT_INT_W=6, otherwise TI alone. The other hardware IP bits come directly from the final sync stage.

## Timing
- All register updates become visible on the edge after the causing cycle.
- c0_res is combinational from current state, so an MFC0 in the same cycle as an MTC0 returns the old value.
- ext_int_in reaches Cause.IP after SYNC_STAGES edges. int_pending and ex_flush follow combinationally in the next cycle that has wb_valid=1.
- TI asserts 1 edge after Count becomes equal to Compare.
- Simultaneous events:
  - An exception together with eret: the exception wins, eret_flush=0 and EXL stays 1.
  - An exception together with MTC0: the write is dropped.
  - A Compare write in the same cycle as an equality: TI is cleared.
  - An MTC0 Count write in the same cycle as a prescaler wrap: the load wins.
- Asserting reset at any time immediately forces all state to its reset values, including mid-prescale and mid-synchroniser.
- With wb_valid=0, no state other than Count, prescaler, TI and IP changes.

## Test plan
- Reset, then MFC0 of Status, Cause and Compare -> 32'h0040_0000, 0, 32'hFFFF_FFFF; ex_pc=32'hBFC0_0380.
- COUNT_DIV=3: MTC0 Count=5 -> Count reads 6 three clocks later. MTC0 Compare=8 -> timer_irq rises 1 edge after Count=8, and an MTC0 Compare write clears it.
- Status=32'h0000_8001 (IM7, IE), TI set, wb_valid=1 -> ex_flush=1, ExcCode 0, EXL=1. A second exception with wb_bd=1 leaves EPC unchanged.
- adel together with ri, wb_pc=32'hBFC0_0100, wb_bd=1, badvaddr=32'h0000_0003 -> ExcCode 0x04, EPC=32'hBFC0_00FC, BD=1, BadVAddr=32'h0000_0003.
- MTC0 EPC=32'h1234 followed by eret -> eret_flush=1, eret_pc=32'h1234, EXL=0. eret together with ov -> eret_flush=0 and ExcCode 0x0c.
- SYNC_STAGES=2, EXT_INT_W=1, IM2=1, IE=1: pulse ext_int_in[0] -> IP2 high exactly 2 edges later. Asserting reset mid-pulse clears IP2 asynchronously.
